// File: rtl/sysctrl_wb_regs_if.sv
// Wishbone slave port bundle for the system-control register bank.
// Signal names keep the bus naming used by the management SoC.
interface sysctrl_wb_regs_if;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport slave (
        input  wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_ack_o, wb_dat_o
    );

    modport master (
        output wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/sysctrl_wb_regs.sv
// System-control register bank: pad-mux destination selects, IRQ source selects,
// and a synchronised rising-edge IRQ capture with sticky pending, mask and irq_o.
module sysctrl_wb_regs #(
    parameter logic [31:0] BASE_ADR    = 32'h2600_0000,
    parameter int          NUM_IRQ     = 4,
    parameter int          SRC_W       = 2,
    parameter int          CLK_DEST_W  = 2,
    parameter int          TRAP_DEST_W = 3
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    sysctrl_wb_regs_if.slave           wb,
    input  logic [NUM_IRQ-1:0]         irq_in,
    output logic [CLK_DEST_W-1:0]      clk_out_dest,
    output logic [TRAP_DEST_W-1:0]     trap_out_dest,
    output logic [NUM_IRQ*SRC_W-1:0]   irq_src_sel,
    output logic                       irq_o
);
    localparam int SEL_W = NUM_IRQ * SRC_W;

    logic                   hit;
    logic                   ack_next;
    logic                   wr;
    logic [5:0]             word;
    logic [31:0]            byte_mask;
    logic [31:0]            rdata;
    logic [CLK_DEST_W-1:0]  clk_nxt;
    logic [TRAP_DEST_W-1:0] trap_nxt;
    logic [SEL_W-1:0]       sel_nxt;
    logic [NUM_IRQ-1:0]     mask, mask_nxt;
    logic [NUM_IRQ-1:0]     pending, pending_nxt;
    logic [NUM_IRQ-1:0]     clr;
    logic [NUM_IRQ-1:0]     s1, s2, s3;
    logic [NUM_IRQ-1:0]     rise;
    logic [1:0]             unused_adr;

    assign unused_adr = wb.wb_adr_i[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] lanes);
        return (old_val & ~lanes) | (new_val & lanes);
    endfunction

    always_comb begin
        hit       = wb.wb_cyc_i & wb.wb_stb_i & (wb.wb_adr_i[31:8] == BASE_ADR[31:8]);
        ack_next  = hit & ~wb.wb_ack_o;
        wr        = ack_next & wb.wb_we_i;
        word      = wb.wb_adr_i[7:2];
        byte_mask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                     {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
        rise      = s2 & ~s3;

        rdata = '0;
        case (word)
            6'h00: rdata = {16'h5C01, 8'(NUM_IRQ), 8'(SRC_W)};
            6'h01: rdata = 32'(clk_out_dest);
            6'h02: rdata = 32'(trap_out_dest);
            6'h03: rdata = 32'(irq_src_sel);
            6'h04: rdata = 32'(pending);
            6'h05: rdata = 32'(mask);
            default: rdata = '0;
        endcase

        clk_nxt  = clk_out_dest;
        trap_nxt = trap_out_dest;
        sel_nxt  = irq_src_sel;
        mask_nxt = mask;
        clr      = '0;
        if (wr) begin
            case (word)
                6'h01: clk_nxt  = CLK_DEST_W'(merge(32'(clk_out_dest), wb.wb_dat_i, byte_mask));
                6'h02: trap_nxt = TRAP_DEST_W'(merge(32'(trap_out_dest), wb.wb_dat_i, byte_mask));
                6'h03: sel_nxt  = SEL_W'(merge(32'(irq_src_sel), wb.wb_dat_i, byte_mask));
                6'h04: clr      = NUM_IRQ'(wb.wb_dat_i & byte_mask);
                6'h05: mask_nxt = NUM_IRQ'(merge(32'(mask), wb.wb_dat_i, byte_mask));
                default: ;
            endcase
        end

        // A new edge outranks a same-cycle W1C so no interrupt is lost.
        pending_nxt = (pending & ~clr) | rise;
    end

    assign irq_o = |(pending & mask);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wb_ack_o   <= 1'b0;
            wb.wb_dat_o   <= '0;
            clk_out_dest  <= '0;
            trap_out_dest <= '0;
            irq_src_sel   <= '0;
            mask          <= '0;
            pending       <= '0;
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
        end else begin
            wb.wb_ack_o   <= ack_next;
            wb.wb_dat_o   <= (ack_next & ~wb.wb_we_i) ? rdata : '0;
            clk_out_dest  <= clk_nxt;
            trap_out_dest <= trap_nxt;
            irq_src_sel   <= sel_nxt;
            mask          <= mask_nxt;
            pending       <= pending_nxt;
            s1            <= irq_in;
            s2            <= s1;
            s3            <= s2;
        end
    end
endmodule

// File: tb/tb_sysctrl_wb_regs.sv
// Bench for sysctrl_wb_regs: directed and randomised bus/IRQ traffic checked
// against a register-level model built from the block's documented rules.
module tb_sysctrl_wb_regs;
    localparam logic [31:0] BASE = 32'h2600_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq_in = '0;
    logic [1:0] clk_out_dest;
    logic [2:0] trap_out_dest;
    logic [7:0] irq_src_sel;
    logic       irq_o;

    int n_cmp = 0;
    int n_err = 0;

    sysctrl_wb_regs_if bus ();

    sysctrl_wb_regs #(.BASE_ADR(BASE)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb            (bus),
        .irq_in        (irq_in),
        .clk_out_dest  (clk_out_dest),
        .trap_out_dest (trap_out_dest),
        .irq_src_sel   (irq_src_sel),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: register contents, expected ack, and per-edge input history.
    logic [31:0] m_clk, m_trap, m_sel, m_mask, m_pend, m_rd;
    logic        m_ack;
    logic [3:0]  hist [4];

    function automatic logic [31:0] mread(input logic [7:0] off);
        case (off)
            8'h00: return 32'h5C01_0402;
            8'h04: return m_clk;
            8'h08: return m_trap;
            8'h0C: return m_sel;
            8'h10: return m_pend;
            8'h14: return m_mask;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clk = 0; m_trap = 0; m_sel = 0; m_mask = 0; m_pend = 0; m_rd = 0; m_ack = 0;
            for (int i = 0; i < 4; i++) hist[i] = '0;
        end else begin
            logic [31:0] clr;
            logic [7:0]  off;
            logic [3:0]  rise;
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq_in;
            // Input sampled two edges ago is high, three edges ago was low.
            rise = hist[2] & ~hist[3];
            clr  = 0;
            m_rd = 0;
            off  = bus.wb_adr_i[7:0] & 8'hFC;
            if (m_ack) begin
                m_ack = 0;
            end else if (bus.wb_cyc_i && bus.wb_stb_i && ((bus.wb_adr_i & 32'hFFFF_FF00) == BASE)) begin
                m_ack = 1;
                if (!bus.wb_we_i) m_rd = mread(off);
                else begin
                    case (off)
                        8'h04: m_clk  = lane_merge(m_clk,  bus.wb_dat_i, bus.wb_sel_i) & 32'h3;
                        8'h08: m_trap = lane_merge(m_trap, bus.wb_dat_i, bus.wb_sel_i) & 32'h7;
                        8'h0C: m_sel  = lane_merge(m_sel,  bus.wb_dat_i, bus.wb_sel_i) & 32'hFF;
                        8'h10: clr    = lane_merge(0,      bus.wb_dat_i, bus.wb_sel_i) & 32'hF;
                        8'h14: m_mask = lane_merge(m_mask, bus.wb_dat_i, bus.wb_sel_i) & 32'hF;
                        default: ;
                    endcase
                end
            end
            m_pend = (m_pend & ~clr) | 32'(rise);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd, output logic acked);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
        bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
        acked = 0; rd = 0;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o === 1'b1) begin
                acked = 1;
                rd = bus.wb_dat_o;
            end
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_clk"},  32'(clk_out_dest),  m_clk);
        chk({tag, "_trap"}, 32'(trap_out_dest), m_trap);
        chk({tag, "_sel"},  32'(irq_src_sel),   m_sel);
        chk({tag, "_irq"},  32'(irq_o),         32'(|(m_pend & m_mask)));
    endtask

    task automatic do_write(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        logic [31:0] rd;
        logic        ak;
        xfer(1'b1, adr, dat, sel, rd, ak);
        chk({tag, "_wack"}, 32'(ak), 32'h1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] adr, output logic [31:0] rd);
        logic ak;
        xfer(1'b0, adr, 32'h0, 4'hF, rd, ak);
        chk({tag, "_rack"}, 32'(ak), 32'h1);
        chk({tag, "_rdat"}, rd, m_rd);
        chk({tag, "_irq"},  32'(irq_o), 32'(|(m_pend & m_mask)));
    endtask

    initial begin
        logic [31:0] rd, a, d;
        logic        ak;
        int          nack;

        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_sel_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.wb_ack_o), 0);
        chk("rst_dat", bus.wb_dat_o, 0);
        chk_outs("rst");
        rst = 0;

        do_read("id", BASE, rd);
        chk("id_val", rd, 32'h5C01_0402);
        @(posedge clk); #1;
        chk("idle_dat", bus.wb_dat_o, 0);

        do_write("w_clk", BASE + 32'h04, 32'h2, 4'hF);
        do_write("w_sel", BASE + 32'h0C, 32'h0000_00E4, 4'hF);
        chk_outs("cfg");
        chk("cfg_clk_const", 32'(clk_out_dest), 32'h2);
        chk("cfg_sel_const", 32'(irq_src_sel), 32'hE4);
        do_read("rb_clk", BASE + 32'h04, rd);
        do_read("rb_sel", BASE + 32'h0C, rd);
        chk("rb_sel_const", rd, 32'hE4);

        do_write("w_lane", BASE + 32'h0C, 32'hFFFF_FF00, 4'b0010);
        chk("lane_sel_const", 32'(irq_src_sel), 32'hE4);
        do_write("w_id", BASE, 32'hFFFF_FFFF, 4'hF);
        do_read("id2", BASE, rd);

        // Edge capture, masked then unmasked.
        do_write("mask0", BASE + 32'h14, 32'h0, 4'hF);
        irq_in[2] = 1;
        repeat (3) @(posedge clk);
        #1 irq_in[2] = 0;
        repeat (4) @(posedge clk);
        #1;
        do_read("pend4", BASE + 32'h10, rd);
        chk("pend4_const", rd, 32'h4);
        chk("pend4_irq", 32'(irq_o), 0);
        do_write("mask4", BASE + 32'h14, 32'h4, 4'hF);
        chk("mask4_irq", 32'(irq_o), 1);
        do_write("w1c4", BASE + 32'h10, 32'h4, 4'hF);
        chk("w1c4_irq", 32'(irq_o), 0);
        do_read("pend0", BASE + 32'h10, rd);
        chk("pend0_const", rd, 32'h0);

        // Held level captures once; W1C then stays clear.
        irq_in[1] = 1;
        repeat (5) @(posedge clk);
        #1;
        do_write("w1c2", BASE + 32'h10, 32'h2, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        do_read("held", BASE + 32'h10, rd);
        chk("held_const", rd & 32'h2, 32'h0);

        // Fresh edge landing on the W1C commit edge: set must win.
        irq_in[1] = 0;
        repeat (4) @(posedge clk);
        #1 irq_in[1] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_write("coinc", BASE + 32'h10, 32'h2, 4'hF);
        do_read("coinc_rd", BASE + 32'h10, rd);
        chk("coinc_const", rd & 32'h2, 32'h2);
        irq_in = 0;

        // Outside the window: never acked, nothing changes.
        xfer(1'b1, BASE + 32'h100, 32'h1, 4'hF, rd, ak);
        chk("oor_ack", 32'(ak), 0);
        chk_outs("oor");
        chk("oor_clk_const", 32'(clk_out_dest), 32'h2);

        // Random register traffic.
        for (int i = 0; i < 24; i++) begin
            a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) do_write("rnd_w", a, d, 4'($urandom));
            else do_read("rnd_r", a, rd);
            chk_outs("rnd");
        end

        // Random IRQ activity interleaved with W1C and reads.
        for (int i = 0; i < 12; i++) begin
            irq_in = 4'($urandom);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            do_write("rirq_w1c", BASE + 32'h10, 32'($urandom_range(0, 15)), 4'($urandom));
            do_read("rirq_rd", BASE + 32'h10, rd);
        end
        irq_in = 0;

        // Reset during an in-flight write, then a held strobe after release.
        @(posedge clk); #1;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = BASE + 32'h08; bus.wb_dat_i = 32'h5; bus.wb_sel_i = 4'hF;
        #2 rst = 1;
        @(posedge clk); #1;
        chk("rstmid_ack", 32'(bus.wb_ack_o), 0);
        chk("rstmid_trap", 32'(trap_out_dest), 0);
        chk_outs("rstmid");
        rst = 0;
        nack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o === 1'b1) nack++;
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        chk("held_stb_acks", 32'(nack), 32'h2);
        chk("post_rst_trap", 32'(trap_out_dest), 32'h5);
        chk_outs("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sysctrl_wb_regs.md
Name: sysctrl_wb_regs

Overview:
Parametrised Wishbone-slave system-control register bank, successor to the fixed housekeeping system-control registers. It holds clock-output and trap-output destination selects and NUM_IRQ per-channel IRQ source selects. It adds a synchronised rising-edge IRQ capture stage with sticky pending bits, a mask, and a combined interrupt output. It sits on the management SoC Wishbone bus beside housekeeping and drives the pad-mux and IRQ-routing logic.

Parameters:
BASE_ADR, 32'h2600_0000, block base address; bits [7:0] must be zero.
NUM_IRQ, 4, number of IRQ channels; legal range 1..16.
SRC_W, 2, width of each channel's source-select field; NUM_IRQ*SRC_W must be ≤ 32.
CLK_DEST_W, 2, width of the clock-output destination field.
TRAP_DEST_W, 3, width of the trap-output destination field.

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous reset, active-high
wb_stb_i  in  1  Wishbone strobe
wb_cyc_i  in  1  Wishbone cycle
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte lane select
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_ack_o  out  1  transfer acknowledge
wb_dat_o  out  32  read data
irq_in  in  NUM_IRQ  asynchronous raw interrupt sources
clk_out_dest  out  CLK_DEST_W  clock-output destination select
trap_out_dest  out  TRAP_DEST_W  trap-output destination select
irq_src_sel  out  NUM_IRQ*SRC_W  packed per-channel source selects; channel k occupies [k*SRC_W +: SRC_W]
irq_o  out  1  OR of (pending & mask)

Behaviour:
- Clocking and reset: single clock wb_clk_i. wb_rst_i is asynchronous, active-high, and clears every flop.
- Reset values: wb_ack_o=0, wb_dat_o=0, clk_out_dest=0, trap_out_dest=0, irq_src_sel=0, mask=0, pending=0, synchroniser and edge flops=0, irq_o=0.
- Address select: sel = wb_cyc_i & wb_stb_i & (wb_adr_i[31:8]==BASE_ADR[31:8]). Register offset is wb_adr_i[7:0]. Bits [1:0] are ignored.
- Handshake: ack is registered, ack_next = sel & ~wb_ack_o, giving one-cycle latency and a one-cycle pulse. A strobe held continuously produces an ack every second cycle; each ack is one transfer.
- Addresses outside the base are never acked and leave all state unchanged.
- Writes commit on the same clock edge that raises wb_ack_o. Each byte lane is written only if its wb_sel_i bit is set.
- Reads: wb_dat_o is registered and valid while wb_ack_o=1. It is 0 in every other cycle. Unused high bits of every register read 0.
- Register map (offsets):
  - 0x00 ID, read-only: {16'h5C01, 8'(NUM_IRQ), 8'(SRC_W)}.
  - 0x04 clk_out_dest, read/write, [CLK_DEST_W-1:0].
  - 0x08 trap_out_dest, read/write, [TRAP_DEST_W-1:0].
  - 0x0C irq_src_sel, read/write, [NUM_IRQ*SRC_W-1:0].
  - 0x10 pending: reads return pending; writing 1 to a bit clears it (W1C); writes of 0 have no effect.
  - 0x14 mask, read/write, [NUM_IRQ-1:0].
  - Other offsets inside the 256-byte window: acked, read 0, writes ignored.
- IRQ capture pipeline, per channel:
  - two-flop synchroniser, then an edge register;
  - rise = s2 & ~s3;
  - pending set on rise.
  - An edge on irq_in first sets pending at the 3rd rising clock edge after the input change, assuming setup is met.
  - A level held high sets pending once only.
  - Pending is set regardless of mask; mask affects only irq_o.
- Simultaneous W1C and rise on the same bit in the same cycle: set wins, and pending stays 1.
- irq_o is combinational from registered pending and mask: glitch-free, no added latency.
- Reset asserted mid-transfer: ack drops to 0 asynchronously and no write commits. After release, a still-asserted strobe is acked normally.
- Writes to the ID register have no effect.

Test Plan:
- Reset release, then read 0x00 with defaults → wb_dat_o=32'h5C01_0402 in the ack cycle; all outputs 0.
- Write 0x04=32'h2, then 0x0C=32'h0000_00E4 with sel=4'hF → clk_out_dest=2'b10, irq_src_sel=8'hE4; read-back matches exactly.
- Write 0x0C=32'hFFFF_FF00 with sel=4'b0010 → irq_src_sel unchanged at 8'hE4, because bits above 7 do not exist and lane 0 is deselected.
- Pulse irq_in[2] high for 3 cycles with mask=0 → pending reads 32'h4 and irq_o=0. Then write mask=4'h4 → irq_o=1. Write 0x10=32'h4 → pending=0 and irq_o=0 on the following cycle.
- Hold irq_in[1] high, clear pending[1] via W1C → pending[1] stays 0. Schedule a fresh rising edge to coincide with a W1C cycle → pending[1]=1.
- Access with address BASE_ADR+32'h100 → no ack within 10 cycles and state unchanged. Assert wb_rst_i during an in-flight write to 0x08 → ack=0 and trap_out_dest=0.
